// File: rtl/seven_seg_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_controller
// Description : Time-multiplexed scan controller for DIGITS common-anode
//               seven-segment digits that share one hex decoder. The display
//               value is snapshotted once per frame so that it never tears,
//               with optional leading-zero suppression and a blanking guard
//               at the start of every digit slot.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                Clk,
  input  logic                nRst,
  input  logic                Enable,
  input  logic [4*DIGITS-1:0] Value,
  input  logic [DIGITS-1:0]   DPMask,
  input  logic                LZBlank,
  output logic [3:0]          Hex,
  output logic                DP,
  output logic [DIGITS-1:0]   DigitSel,
  output logic                FrameStart
);

  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  C_CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] C_SLOT_MAX = SLOT_W'(DIGITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  // Registered state and outputs
  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [SLOT_W-1:0]   r_slot;
  logic [4*DIGITS-1:0] r_snap_val;
  logic [DIGITS-1:0]   r_snap_dp;
  logic [DIGITS-1:0]   r_snap_lz;
  logic [3:0]          r_hex;
  logic                r_dp;
  logic [DIGITS-1:0]   r_sel;
  logic                r_frame_start;

  // Next-state values
  logic [1:0]          w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [SLOT_W-1:0]   w_slot_nxt;
  logic [4*DIGITS-1:0] w_snap_val_nxt;
  logic [DIGITS-1:0]   w_snap_dp_nxt;
  logic [DIGITS-1:0]   w_snap_lz_nxt;
  logic                w_take_snap;

  // Next output values
  logic [3:0]          w_hex_nxt;
  logic                w_dp_nxt;
  logic [DIGITS-1:0]   w_sel_nxt;
  logic                w_frame_start_nxt;

  // Leading-zero flags of the live inputs
  logic [DIGITS-1:0]   w_lz;
  logic                w_lz_run;

  assign Hex        = r_hex;
  assign DP         = r_dp;
  assign DigitSel   = r_sel;
  assign FrameStart = r_frame_start;

  // A digit is suppressed when it and every digit above it is zero; digit 0
  // always stays lit so that a zero value still shows "0".
  always_comb begin
    w_lz     = '0;
    w_lz_run = LZBlank;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_lz_run = w_lz_run & (Value[4*i +: 4] == 4'h0);
      w_lz[i]  = w_lz_run;
    end
  end

  // State register, counters, snapshots and registered outputs
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_slot        <= '0;
      r_snap_val    <= '0;
      r_snap_dp     <= '0;
      r_snap_lz     <= '0;
      r_hex         <= 4'h0;
      r_dp          <= 1'b0;
      r_sel         <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_slot        <= w_slot_nxt;
      r_snap_val    <= w_snap_val_nxt;
      r_snap_dp     <= w_snap_dp_nxt;
      r_snap_lz     <= w_snap_lz_nxt;
      r_hex         <= w_hex_nxt;
      r_dp          <= w_dp_nxt;
      r_sel         <= w_sel_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  // Next-state: slot timing, frame wrap and snapshot capture. BLANK/SHOW is
  // derived from the next counter value so outputs line up with the counter.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_slot_nxt     = r_slot;
    w_snap_val_nxt = r_snap_val;
    w_snap_dp_nxt  = r_snap_dp;
    w_snap_lz_nxt  = r_snap_lz;
    w_take_snap    = 1'b0;

    if (!Enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_slot_nxt  = '0;
    end else begin
      if (r_state == S_IDLE) begin
        w_take_snap = 1'b1;
        w_cnt_nxt   = '0;
        w_slot_nxt  = '0;
      end else if (r_cnt == C_CNT_MAX) begin
        w_cnt_nxt = '0;
        if (r_slot == C_SLOT_MAX) begin
          w_slot_nxt  = '0;
          w_take_snap = 1'b1;
        end else begin
          w_slot_nxt = r_slot + SLOT_W'(1);
        end
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end

      if (w_take_snap) begin
        w_snap_val_nxt = Value;
        w_snap_dp_nxt  = DPMask;
        w_snap_lz_nxt  = w_lz;
      end

      w_state_nxt = (int'(w_cnt_nxt) < BLANK_CYCLES) ? S_BLANK : S_SHOW;
    end
  end

  // Outputs: Hex/DP are loaded for the whole slot (including the guard) so
  // the decoder has settled before the anode is switched on.
  always_comb begin
    w_hex_nxt         = w_snap_val_nxt[4*w_slot_nxt +: 4];
    w_dp_nxt          = w_snap_dp_nxt[w_slot_nxt] & ~w_snap_lz_nxt[w_slot_nxt];
    w_sel_nxt         = '1;
    w_frame_start_nxt = w_take_snap;
    if ((w_state_nxt == S_SHOW) && !w_snap_lz_nxt[w_slot_nxt]) begin
      w_sel_nxt = ~(DIGITS'(1) << w_slot_nxt);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_controller
// Description : Self-checking bench for seven_seg_scan_controller with
//               DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, plus a second
//               instance with BLANK_CYCLES=0 sharing the same inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_controller;

  localparam int DIGITS = 4;
  localparam int RDIV   = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * RDIV;

  logic        Clk = 1'b0;
  logic        nRst;
  logic        Enable;
  logic [15:0] Value;
  logic [3:0]  DPMask;
  logic        LZBlank;
  logic [3:0]  Hex, Hex0;
  logic        DP, DP0;
  logic [3:0]  DigitSel, DigitSel0;
  logic        FrameStart, FrameStart0;

  int checks  = 0;
  int errors  = 0;
  int overlap = 0;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] hex;
    logic       dp;
    logic       fs;
    logic [3:0] sel0;
  } exp_t;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dpm;
    logic        lz;
    logic        mid_en;
    logic [15:0] mid_value;
  } vec_t;

  exp_t q[$];
  vec_t tbl[7];

  always #5 Clk = ~Clk;

  seven_seg_scan_controller #(
    .DIGITS(DIGITS), .REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANK)
  ) dut (
    .Clk(Clk), .nRst(nRst), .Enable(Enable), .Value(Value), .DPMask(DPMask),
    .LZBlank(LZBlank), .Hex(Hex), .DP(DP), .DigitSel(DigitSel),
    .FrameStart(FrameStart)
  );

  seven_seg_scan_controller #(
    .DIGITS(DIGITS), .REFRESH_DIV(RDIV), .BLANK_CYCLES(0)
  ) dut0 (
    .Clk(Clk), .nRst(nRst), .Enable(Enable), .Value(Value), .DPMask(DPMask),
    .LZBlank(LZBlank), .Hex(Hex0), .DP(DP0), .DigitSel(DigitSel0),
    .FrameStart(FrameStart0)
  );

  // Anti-ghosting monitor: never more than one anode on
  always @(negedge Clk) begin
    if ($countones(~DigitSel) > 1 || $countones(~DigitSel0) > 1) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic suppressed(input logic [15:0] v, input logic lz, input int s);
    if (s == 0 || !lz) return 1'b0;
    for (int j = s; j < DIGITS; j++) begin
      if (v[4*j +: 4] != 4'h0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Expected outputs for one whole frame, starting with the snapshot edge
  task automatic push_frame(input logic [15:0] v, input logic [3:0] dpm, input logic lz);
    exp_t e;
    logic sup;
    for (int s = 0; s < DIGITS; s++) begin
      sup = suppressed(v, lz, s);
      for (int c = 0; c < RDIV; c++) begin
        e.fs   = (s == 0 && c == 0);
        e.hex  = v[4*s +: 4];
        e.dp   = dpm[s] & ~sup;
        e.sel  = (c < BLANK || sup) ? 4'hF : ~(4'b0001 << s);
        e.sel0 = sup ? 4'hF : ~(4'b0001 << s);
        q.push_back(e);
      end
    end
  endtask

  task automatic compare(input string tag, input exp_t e);
    checks++;
    if ({DigitSel, Hex, DP, FrameStart, DigitSel0} !== {e.sel, e.hex, e.dp, e.fs, e.sel0}) begin
      errors++;
      $display("FAIL %s: got sel=%b hex=%h dp=%b fs=%b sel0=%b, expected sel=%b hex=%h dp=%b fs=%b sel0=%b",
               tag, DigitSel, Hex, DP, FrameStart, DigitSel0, e.sel, e.hex, e.dp, e.fs, e.sel0);
    end
  endtask

  task automatic check_cycle(input string tag);
    exp_t e;
    @(posedge Clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      compare(tag, e);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    exp_t e;
    e.sel = 4'hF; e.hex = 4'h0; e.dp = 1'b0; e.fs = 1'b0; e.sel0 = 4'hF;
    compare(tag, e);
  endtask

  task automatic check_idle_sel(input string tag);
    checks++;
    if ({DigitSel, FrameStart, DigitSel0} !== {4'hF, 1'b0, 4'hF}) begin
      errors++;
      $display("FAIL %s: got sel=%b fs=%b sel0=%b, expected sel=1111 fs=0 sel0=1111",
               tag, DigitSel, FrameStart, DigitSel0);
    end
  endtask

  task automatic run_frame(input string tag, input int ncyc);
    for (int c = 0; c < ncyc; c++) check_cycle($sformatf("%s_c%0d", tag, c));
  endtask

  initial begin
    //          value     dpm      lz    mid   mid_value
    tbl[0] = '{16'h1A3F, 4'b0100, 1'b0, 1'b1, 16'h5555};
    tbl[1] = '{16'h5555, 4'b0000, 1'b0, 1'b0, 16'h0000};
    tbl[2] = '{16'h0070, 4'b1111, 1'b1, 1'b0, 16'h0000};
    tbl[3] = '{16'h0000, 4'b1111, 1'b1, 1'b0, 16'h0000};
    tbl[4] = '{16'h0070, 4'b0000, 1'b0, 1'b0, 16'h0000};
    tbl[5] = '{16'h8000, 4'b0001, 1'b1, 1'b0, 16'h0000};
    tbl[6] = '{16'h0B0C, 4'b1010, 1'b1, 1'b0, 16'h0000};

    nRst = 1'b0; Enable = 1'b0; Value = '0; DPMask = '0; LZBlank = 1'b0;
    repeat (3) @(posedge Clk);
    #1 check_reset_vals("reset");
    @(negedge Clk) nRst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk);
      #1 check_reset_vals("idle_disabled");
    end

    // Back-to-back frames from the table; inputs set just before each wrap edge
    for (int v = 0; v < 7; v++) begin
      Value = tbl[v].value; DPMask = tbl[v].dpm; LZBlank = tbl[v].lz; Enable = 1'b1;
      push_frame(tbl[v].value, tbl[v].dpm, tbl[v].lz);
      for (int c = 0; c < FRAME; c++) begin
        check_cycle($sformatf("vec%0d_c%0d", v, c));
        if (tbl[v].mid_en && c == 10) Value = tbl[v].mid_value;
      end
    end

    // Drop Enable during SHOW of slot 2
    Value = 16'h1A3F; DPMask = 4'b0100; LZBlank = 1'b0;
    push_frame(Value, DPMask, LZBlank);
    run_frame("pre_drop", 2*RDIV + BLANK + 2);
    Enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1 check_idle_sel($sformatf("drop_idle%0d", i));
    end
    q.delete();
    Enable = 1'b1; Value = 16'h0B0C; DPMask = 4'b0011; LZBlank = 1'b1;
    push_frame(Value, DPMask, LZBlank);
    run_frame("reenable", FRAME);

    // Asynchronous reset in the middle of slot 1 SHOW
    Value = 16'h1A3F; DPMask = 4'b0010; LZBlank = 1'b0;
    push_frame(Value, DPMask, LZBlank);
    run_frame("pre_rst", RDIV + BLANK + 2);
    #3 nRst = 1'b0;
    #1 check_reset_vals("async_rst");
    q.delete();
    @(posedge Clk);
    @(negedge Clk) nRst = 1'b1;
    Value = 16'h2468; DPMask = 4'b1000; LZBlank = 1'b0;
    push_frame(Value, DPMask, LZBlank);
    run_frame("post_rst", FRAME);
    Value = 16'h00F0; DPMask = 4'b0101; LZBlank = 1'b1;
    push_frame(Value, DPMask, LZBlank);
    run_frame("post_rst2", FRAME);

    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL anode_overlap: got %0d cycles with >1 select low, expected 0", overlap);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
